hsi_batch_seq: RTL and testbench



---
 rtl/hsi_batch_seq.sv | 191 +++++++++++++++++++
 tb/tb_hsi_batch_seq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsi_batch_seq.sv
// Batch sequencer for one hsi_accel_obi: programs OP_CODE/NUM_BANDS over OBI, then per vector pair
// pushes operands, issues START, checks STATUS, pops the result and hands it to a valid/ready sink.
module hsi_batch_seq #(
    parameter int          COMPONENT_WIDTH = 16,
    parameter int          COMPONENTS_MAX  = 3,
    parameter int          CNT_W           = 16,
    parameter logic [31:0] ACC_BASE        = 32'h0,
    localparam int         VEC_W           = COMPONENT_WIDTH * COMPONENTS_MAX
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_start_i,
    input  logic [31:0]      cfg_op_i,
    input  logic [31:0]      cfg_bands_i,
    input  logic [CNT_W-1:0] cfg_count_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [3:0]       err_code_o,
    output logic [CNT_W-1:0] processed_o,
    input  logic             src_valid_i,
    output logic             src_ready_o,
    input  logic [VEC_W-1:0] src_a_i,
    input  logic [VEC_W-1:0] src_b_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [VEC_W-1:0] res_data_o,
    output logic             obi_req_o,
    output logic             obi_we_o,
    output logic [3:0]       obi_be_o,
    output logic [31:0]      obi_addr_o,
    output logic [31:0]      obi_wdata_o,
    input  logic             obi_gnt_i,
    input  logic             obi_rvalid_i,
    input  logic [31:0]      obi_rdata_i,
    output logic             acc_in1_wr_en_o,
    output logic             acc_in2_wr_en_o,
    output logic [VEC_W-1:0] acc_in1_data_o,
    output logic [VEC_W-1:0] acc_in2_data_o,
    output logic             acc_out_rd_en_o,
    input  logic             acc_out_empty_i,
    input  logic [VEC_W-1:0] acc_out_data_i
);

    localparam logic [31:0] OFS_OP     = 32'h00;
    localparam logic [31:0] OFS_BANDS  = 32'h04;
    localparam logic [31:0] OFS_START  = 32'h08;
    localparam logic [31:0] OFS_STATUS = 32'h0C;

    typedef enum logic [3:0] {
        IDLE, WR_OP, WR_BANDS, PUSH, WR_START, RD_STAT, WAIT_RES, POP, CAPT, EMIT, FINISH
    } state_t;

    state_t             state_reg, state_next;
    logic               pend_reg, pend_next;
    logic [31:0]        op_reg, bands_reg;
    logic [CNT_W-1:0]   count_reg, processed_reg;
    logic               err_reg;
    logic [3:0]         err_code_reg;
    logic [VEC_W-1:0]   res_data_reg;
    logic               bus_state, bus_done, accept_start, stat_err, emit_fire, push_fire;
    logic [CNT_W:0]     proc_inc;
    logic               last_vec;
    logic               unused_rdata;

    assign unused_rdata = ^{obi_rdata_i[31:5], obi_rdata_i[0]};
    assign proc_inc     = {1'b0, processed_reg} + (CNT_W+1)'(1);
    assign last_vec     = (proc_inc == {1'b0, count_reg});
    assign bus_state    = (state_reg == WR_OP) || (state_reg == WR_BANDS) ||
                          (state_reg == WR_START) || (state_reg == RD_STAT);

    always_comb begin
        state_next      = state_reg;
        pend_next       = pend_reg;
        obi_req_o       = 1'b0;
        obi_we_o        = 1'b0;
        obi_addr_o      = '0;
        obi_wdata_o     = '0;
        src_ready_o     = 1'b0;
        push_fire       = 1'b0;
        acc_out_rd_en_o = 1'b0;
        res_valid_o     = 1'b0;
        done_o          = 1'b0;
        bus_done        = 1'b0;
        accept_start    = 1'b0;
        stat_err        = 1'b0;
        emit_fire       = 1'b0;

        case (state_reg)
            WR_OP:    begin obi_we_o = 1'b1; obi_addr_o = ACC_BASE + OFS_OP;     obi_wdata_o = op_reg;    end
            WR_BANDS: begin obi_we_o = 1'b1; obi_addr_o = ACC_BASE + OFS_BANDS;  obi_wdata_o = bands_reg; end
            WR_START: begin obi_we_o = 1'b1; obi_addr_o = ACC_BASE + OFS_START;  obi_wdata_o = 32'h1;     end
            RD_STAT:  begin                  obi_addr_o = ACC_BASE + OFS_STATUS;                          end
            default:  ;
        endcase

        // Request phase holds until grant; response phase waits for rvalid with req low.
        if (bus_state) begin
            if (!pend_reg) begin
                obi_req_o = 1'b1;
                if (obi_gnt_i) pend_next = 1'b1;
            end else if (obi_rvalid_i) begin
                pend_next = 1'b0;
                bus_done  = 1'b1;
            end
        end

        case (state_reg)
            IDLE: if (cfg_start_i) begin
                accept_start = 1'b1;
                state_next   = (cfg_count_i == '0) ? FINISH : WR_OP;
            end
            WR_OP:    if (bus_done) state_next = WR_BANDS;
            WR_BANDS: if (bus_done) state_next = PUSH;
            PUSH: begin
                src_ready_o = 1'b1;
                if (src_valid_i) begin
                    push_fire  = 1'b1;
                    state_next = WR_START;
                end
            end
            WR_START: if (bus_done) state_next = RD_STAT;
            RD_STAT: if (bus_done) begin
                stat_err   = (obi_rdata_i[4:1] != 4'd0);
                state_next = stat_err ? FINISH : WAIT_RES;
            end
            WAIT_RES: if (!acc_out_empty_i) state_next = POP;
            POP: begin
                acc_out_rd_en_o = 1'b1;
                state_next      = CAPT;
            end
            CAPT: state_next = EMIT;
            EMIT: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    emit_fire  = 1'b1;
                    state_next = last_vec ? FINISH : PUSH;
                end
            end
            FINISH: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            pend_reg      <= 1'b0;
            op_reg        <= '0;
            bands_reg     <= '0;
            count_reg     <= '0;
            processed_reg <= '0;
            err_reg       <= 1'b0;
            err_code_reg  <= '0;
            res_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            if (accept_start) begin
                op_reg        <= cfg_op_i;
                bands_reg     <= cfg_bands_i;
                count_reg     <= cfg_count_i;
                processed_reg <= '0;
                err_reg       <= 1'b0;
                err_code_reg  <= '0;
            end
            if (stat_err) begin
                err_reg      <= 1'b1;
                err_code_reg <= obi_rdata_i[4:1];
            end
            if (state_reg == CAPT) res_data_reg <= acc_out_data_i;
            if (emit_fire && (processed_reg != '1)) processed_reg <= proc_inc[CNT_W-1:0];
        end
    end

    assign busy_o          = (state_reg != IDLE);
    assign err_o           = err_reg;
    assign err_code_o      = err_code_reg;
    assign processed_o     = processed_reg;
    assign res_data_o      = res_data_reg;
    assign obi_be_o        = 4'hF;
    assign acc_in1_wr_en_o = push_fire;
    assign acc_in2_wr_en_o = push_fire;
    // Operands are only driven during the push so the FIFO inputs idle at zero.
    assign acc_in1_data_o  = push_fire ? src_a_i : '0;
    assign acc_in2_data_o  = push_fire ? src_b_i : '0;

endmodule

// File: tb/tb_hsi_batch_seq.sv
// Bench for hsi_batch_seq: behavioural OBI slave and accelerator stub, table-driven batches,
// plus hand-written backpressure, grant-delay, busy-start and mid-batch reset sequences.
module tb_hsi_batch_seq;

    localparam int VEC_W = 48;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             cfg_start_i = 1'b0;
    logic [31:0]      cfg_op_i = '0;
    logic [31:0]      cfg_bands_i = '0;
    logic [CNT_W-1:0] cfg_count_i = '0;
    logic             busy_o, done_o, err_o;
    logic [3:0]       err_code_o;
    logic [CNT_W-1:0] processed_o;
    logic             src_valid_i = 1'b0;
    logic             src_ready_o;
    logic [VEC_W-1:0] src_a_i = '0, src_b_i = '0;
    logic             res_valid_o;
    logic             res_ready_i = 1'b1;
    logic [VEC_W-1:0] res_data_o;
    logic             obi_req_o, obi_we_o;
    logic [3:0]       obi_be_o;
    logic [31:0]      obi_addr_o, obi_wdata_o;
    logic             obi_gnt_i;
    logic             obi_rvalid_i = 1'b0;
    logic [31:0]      obi_rdata_i = '0;
    logic             acc_in1_wr_en_o, acc_in2_wr_en_o, acc_out_rd_en_o;
    logic [VEC_W-1:0] acc_in1_data_o, acc_in2_data_o;
    logic             acc_out_empty_i = 1'b1;
    logic [VEC_W-1:0] acc_out_data_i = '0;

    hsi_batch_seq #(.COMPONENT_WIDTH(16), .COMPONENTS_MAX(3), .CNT_W(CNT_W), .ACC_BASE(32'h0)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cfg_start_i(cfg_start_i), .cfg_op_i(cfg_op_i), .cfg_bands_i(cfg_bands_i), .cfg_count_i(cfg_count_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o), .processed_o(processed_o),
        .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_a_i(src_a_i), .src_b_i(src_b_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .obi_req_o(obi_req_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_addr_o(obi_addr_o),
        .obi_wdata_o(obi_wdata_o), .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
        .acc_in1_wr_en_o(acc_in1_wr_en_o), .acc_in2_wr_en_o(acc_in2_wr_en_o),
        .acc_in1_data_o(acc_in1_data_o), .acc_in2_data_o(acc_in2_data_o),
        .acc_out_rd_en_o(acc_out_rd_en_o), .acc_out_empty_i(acc_out_empty_i), .acc_out_data_i(acc_out_data_i)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_miss = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0;
    int op_wr = 0, bands_wr = 0, req_cnt = 0, rd_cnt = 0, done_cnt = 0, src_taken = 0, viol = 0;
    int gnt_wait = 0, gnt_delay = 0;
    logic clr_req = 1'b0;
    logic [VEC_W-1:0] src_a_q[$], src_b_q[$], in1_q[$], in2_q[$], out_q[$], got_q[$];
    logic [31:0] acc_op = '0, acc_bands = '0;
    logic [3:0]  acc_code = '0;

    // Snapshots of the DUT outputs taken at the clock edge, consumed by the environment at negedge.
    logic s_src_fire = 0, s_wr1 = 0, s_wr2 = 0, s_req = 0, s_gnt = 0, s_we = 0, s_rd = 0;
    logic [VEC_W-1:0] s_in1 = '0, s_in2 = '0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic p_pend = 0, p_we = 0;
    logic [31:0] p_addr = '0, p_wdata = '0;

    assign obi_gnt_i = obi_req_o && (gnt_wait >= gnt_delay);

    function automatic logic [VEC_W-1:0] mk(input int c0, input int c1, input int c2);
        return {c0[15:0], c1[15:0], c2[15:0]};
    endfunction

    function automatic logic [2:0][VEC_W-1:0] p3(input logic [VEC_W-1:0] x0, x1, x2);
        return {x2, x1, x0};
    endfunction

    function automatic logic [1:0][VEC_W-1:0] p2(input logic [VEC_W-1:0] x0, x1);
        return {x1, x0};
    endfunction

    function automatic logic [3:0] acc_status(input logic [31:0] op, input logic [31:0] bands);
        if (op == 32'd1) return (bands == 32'd3) ? 4'd0 : 4'd1;
        if (op == 32'd2) return (bands > 32'd3 || bands == 32'd0) ? 4'd4 : 4'd0;
        return 4'd2;
    endfunction

    function automatic logic [VEC_W-1:0] acc_calc(input logic [31:0] op, input logic [VEC_W-1:0] a, b);
        logic [15:0] a0, a1, a2, b0, b1, b2;
        {a0, a1, a2} = a;
        {b0, b1, b2} = b;
        if (op == 32'd1) return {16'(a1*b2 - a2*b1), 16'(a2*b0 - a0*b2), 16'(a0*b1 - a1*b0)};
        return {16'd0, 16'd0, 16'(a0*b0 + a1*b1 + a2*b2)};
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_ni) begin
            p_pend = 0; s_src_fire = 0; s_wr1 = 0; s_wr2 = 0; s_req = 0; s_gnt = 0; s_rd = 0;
        end else begin
            s_src_fire = src_valid_i && src_ready_o;
            s_wr1 = acc_in1_wr_en_o; s_in1 = acc_in1_data_o;
            s_wr2 = acc_in2_wr_en_o; s_in2 = acc_in2_data_o;
            s_req = obi_req_o; s_gnt = obi_req_o && obi_gnt_i;
            s_we = obi_we_o; s_addr = obi_addr_o; s_wdata = obi_wdata_o;
            s_rd = acc_out_rd_en_o;
            if (s_gnt) begin
                req_cnt++;
                if (obi_we_o && obi_addr_o == 32'h0) op_wr++;
                if (obi_we_o && obi_addr_o == 32'h4) bands_wr++;
            end
            if (s_rd) rd_cnt++;
            if (done_o) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
            if (res_valid_o && res_ready_i) got_q.push_back(res_data_o);
            if (src_ready_o && res_valid_o) viol++;
            if (obi_be_o != 4'hF) viol++;
            if (p_pend && (!obi_req_o || obi_addr_o != p_addr || obi_wdata_o != p_wdata || obi_we_o != p_we)) viol++;
            p_pend = obi_req_o && !obi_gnt_i;
            p_addr = obi_addr_o; p_wdata = obi_wdata_o; p_we = obi_we_o;
        end
    end

    always @(negedge clk) begin
        logic [VEC_W-1:0] ta, tb;
        if (!rst_ni || clr_req) begin
            src_a_q.delete(); src_b_q.delete(); in1_q.delete(); in2_q.delete(); out_q.delete();
            gnt_wait = 0; obi_rvalid_i = 0; obi_rdata_i = '0; acc_out_data_i = '0;
            acc_op = '0; acc_bands = '0; acc_code = '0;
        end else begin
            if (s_src_fire && src_a_q.size() > 0) begin
                ta = src_a_q.pop_front(); tb = src_b_q.pop_front(); src_taken++;
            end
            if (s_wr1) in1_q.push_back(s_in1);
            if (s_wr2) in2_q.push_back(s_in2);
            obi_rvalid_i = 1'b0;
            obi_rdata_i  = '0;
            if (s_gnt) begin
                gnt_wait = 0;
                obi_rvalid_i = 1'b1;
                if (s_we) begin
                    if (s_addr == 32'h0) acc_op = s_wdata;
                    if (s_addr == 32'h4) acc_bands = s_wdata;
                    if (s_addr == 32'h8) begin
                        acc_code = acc_status(acc_op, acc_bands);
                        if (acc_code == 4'd0 && in1_q.size() > 0 && in2_q.size() > 0) begin
                            ta = in1_q.pop_front(); tb = in2_q.pop_front();
                            out_q.push_back(acc_calc(acc_op, ta, tb));
                        end
                    end
                end else if (s_addr == 32'hC) begin
                    obi_rdata_i = {27'd0, acc_code, 1'b1};
                end
            end else if (s_req) begin
                gnt_wait++;
            end
            if (s_rd && out_q.size() > 0) acc_out_data_i = out_q.pop_front();
        end
        acc_out_empty_i = (out_q.size() == 0);
        src_valid_i = (src_a_q.size() > 0);
        src_a_i = src_valid_i ? src_a_q[0] : '0;
        src_b_i = src_valid_i ? src_b_q[0] : '0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic clear_env();
        clr_req = 1'b1;
        repeat (2) @(negedge clk);
        clr_req = 1'b0;
        op_wr = 0; bands_wr = 0; req_cnt = 0; rd_cnt = 0; done_cnt = 0; src_taken = 0;
        got_q.delete();
    endtask

    task automatic start_batch(input logic [31:0] op, input logic [31:0] bands, input logic [15:0] count);
        @(negedge clk);
        cfg_op_i = op; cfg_bands_i = bands; cfg_count_i = count;
        cfg_start_i = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        cfg_start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int t = 0; t < 400 && done_cnt == 0; t++) @(negedge clk);
        if (done_cnt == 0) begin
            n_vec++; n_miss++;
            $display("FAIL %s: got no done_o expected done_o within 400 cycles", name);
        end
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] op;
        logic [31:0] bands;
        logic [15:0] count;
        int npairs;
        logic [2:0][VEC_W-1:0] a;
        logic [2:0][VEC_W-1:0] b;
        int nres;
        logic [1:0][VEC_W-1:0] r;
        logic err;
        logic [3:0] code;
        int proc;
        int reqs;
        int src;
    } vec_t;

    vec_t tv[5];

    initial begin
        logic [VEC_W-1:0] z, d0;
        z = '0;
        tv[0] = '{32'd1, 32'd3, 16'd2, 2, p3(mk(1,0,0), mk(0,1,0), z), p3(mk(0,1,0), mk(0,0,1), z),
                  2, p2(mk(0,0,1), mk(1,0,0)), 1'b0, 4'd0, 2, 6, 2};
        tv[1] = '{32'd2, 32'd3, 16'd1, 1, p3(mk(1,2,3), z, z), p3(mk(4,5,6), z, z),
                  1, p2(mk(0,0,32), z), 1'b0, 4'd0, 1, 4, 1};
        tv[2] = '{32'd1, 32'd2, 16'd3, 3, p3(mk(1,0,0), mk(0,1,0), mk(0,0,1)), p3(mk(0,1,0), mk(0,0,1), mk(1,0,0)),
                  0, p2(z, z), 1'b1, 4'd1, 0, 4, 1};
        tv[3] = '{32'd1, 32'd3, 16'd0, 0, p3(z, z, z), p3(z, z, z),
                  0, p2(z, z), 1'b0, 4'd0, 0, 0, 0};
        tv[4] = '{32'd2, 32'd4, 16'd1, 1, p3(mk(1,2,3), z, z), p3(mk(4,5,6), z, z),
                  0, p2(z, z), 1'b1, 4'd4, 0, 4, 1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst busy", busy_o, 0);
        chk("rst done", done_o, 0);
        chk("rst err", {err_o, err_code_o}, 0);
        chk("rst processed", processed_o, 0);
        chk("rst obi req/we", {obi_req_o, obi_we_o}, 0);
        chk("rst obi be", obi_be_o, 4'hF);
        chk("rst obi addr", obi_addr_o, 0);
        chk("rst handshakes", {src_ready_o, res_valid_o, acc_out_rd_en_o, acc_in1_wr_en_o}, 0);
        chk("rst res data", res_data_o, 0);
        chk("rst acc data", {acc_in1_data_o, acc_in2_data_o}, 0);
        rst_ni = 1'b1;

        for (int i = 0; i < 5; i++) begin
            clear_env();
            for (int k = 0; k < tv[i].npairs; k++) begin
                src_a_q.push_back(tv[i].a[k]);
                src_b_q.push_back(tv[i].b[k]);
            end
            start_batch(tv[i].op, tv[i].bands, tv[i].count);
            wait_done($sformatf("v%0d done", i));
            chk($sformatf("v%0d results", i), got_q.size(), tv[i].nres);
            for (int k = 0; k < tv[i].nres && k < got_q.size(); k++)
                chk($sformatf("v%0d res%0d", i, k), got_q[k], tv[i].r[k]);
            chk($sformatf("v%0d processed", i), processed_o, tv[i].proc);
            chk($sformatf("v%0d err", i), err_o, tv[i].err);
            chk($sformatf("v%0d err_code", i), err_code_o, tv[i].code);
            chk($sformatf("v%0d done pulses", i), done_cnt, 1);
            chk($sformatf("v%0d op writes", i), op_wr, (tv[i].count != 0) ? 1 : 0);
            chk($sformatf("v%0d bands writes", i), bands_wr, (tv[i].count != 0) ? 1 : 0);
            chk($sformatf("v%0d obi txns", i), req_cnt, tv[i].reqs);
            chk($sformatf("v%0d pops", i), rd_cnt, tv[i].nres);
            chk($sformatf("v%0d src consumed", i), src_taken, tv[i].src);
            chk($sformatf("v%0d busy after", i), busy_o, 0);
            if (tv[i].count == 0) chk($sformatf("v%0d done latency", i), done_cyc - start_cyc, 2);
        end

        // Result backpressure: sink stalls 5 cycles
        clear_env();
        src_a_q.push_back(mk(1,2,3)); src_b_q.push_back(mk(4,5,6));
        res_ready_i = 1'b0;
        start_batch(32'd2, 32'd3, 16'd1);
        for (int t = 0; t < 100 && !res_valid_o; t++) @(negedge clk);
        chk("bp valid seen", res_valid_o, 1);
        d0 = res_data_o;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d valid/src_ready", k), {res_valid_o, src_ready_o}, 2'b10);
            chk($sformatf("bp hold%0d data", k), res_data_o, mk(0,0,32));
        end
        res_ready_i = 1'b1;
        wait_done("bp done");
        chk("bp processed", processed_o, 1);
        chk("bp delivered", (got_q.size() == 1) ? got_q[0] : '1, mk(0,0,32));

        // Grant delayed 3 cycles; a second start while busy must be ignored
        clear_env();
        gnt_delay = 3;
        src_a_q.push_back(mk(1,0,0)); src_b_q.push_back(mk(0,1,0));
        start_batch(32'd1, 32'd3, 16'd1);
        for (int t = 0; t < 20 && !obi_req_o; t++) @(negedge clk);
        chk("gd req seen", obi_req_o, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("gd stall%0d req/we", k), {obi_req_o, obi_we_o}, 2'b11);
            chk($sformatf("gd stall%0d addr", k), obi_addr_o, 32'h0);
            chk($sformatf("gd stall%0d wdata", k), obi_wdata_o, 32'h1);
        end
        cfg_count_i = 16'd0;
        cfg_start_i = 1'b1;
        @(negedge clk);
        cfg_start_i = 1'b0;
        wait_done("gd done");
        gnt_delay = 0;
        chk("gd processed", processed_o, 1);
        chk("gd result", (got_q.size() == 1) ? got_q[0] : '1, mk(0,0,1));
        chk("gd done pulses", done_cnt, 1);
        chk("gd obi txns", req_cnt, 4);

        // Reset mid-batch drops the request at once
        clear_env();
        src_a_q.push_back(mk(1,0,0)); src_b_q.push_back(mk(0,1,0));
        start_batch(32'd1, 32'd3, 16'd2);
        for (int t = 0; t < 20 && !obi_req_o; t++) @(negedge clk);
        #1 rst_ni = 1'b0;
        #1;
        chk("midrst req/busy", {obi_req_o, busy_o}, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst idle", {busy_o, obi_req_o, src_ready_o}, 0);

        chk("protocol violations", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
